// File: rtl/nap_timer_pkg.sv
// Shared types and helpers for the nap timer: FSM state encoding, BCD field layout and
// a validity check for hh:mm:ss BCD values.
package nap_timer_pkg;

  localparam int unsigned BCD_W   = 24;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned NUM_DIG = BCD_W / DIG_W;

  localparam int unsigned H10_LSB = 20;
  localparam int unsigned H1_LSB  = 16;
  localparam int unsigned M10_LSB = 12;
  localparam int unsigned M1_LSB  = 8;
  localparam int unsigned S10_LSB = 4;
  localparam int unsigned S1_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StPause,
    StAlarm
  } nap_state_e;

  // Every digit must be decimal; tens of minutes and tens of seconds stop at 5.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (v[i*DIG_W +: DIG_W] > 4'd9) ok = 1'b0;
    end
    if (v[M10_LSB +: DIG_W] > 4'd5) ok = 1'b0;
    if (v[S10_LSB +: DIG_W] > 4'd5) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/nap_prescaler.sv
// Free-running 0..TICKS-1 counter with freeze (en low) and synchronous clear.
// tick is high in the cycle the counter wraps while enabled.
module nap_prescaler #(
  parameter int unsigned TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nap_timer_ctrl.sv
// Countdown sequencer: owns time/preset registers, paces one decrement handshake per second
// and drives a timed alarm at zero. Optional snooze path under NAP_TIMER_SNOOZE_EN.
module nap_timer_ctrl
  import nap_timer_pkg::*;
#(
`ifdef NAP_TIMER_SNOOZE_EN
  parameter logic [23:0] SNOOZE_BCD = 24'h000500,
`endif
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned ALARM_SECS    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_clear,
`ifdef NAP_TIMER_SNOOZE_EN
  input  logic        btn_snooze,
`endif
  input  logic        load_en,
  input  logic [23:0] load_bcd,
  output logic        load_err,
  output logic        dec_req,
  output logic [23:0] dec_cur,
  input  logic        dec_ack,
  input  logic [23:0] dec_next,
  input  logic        dec_zero,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        alarm,
  output logic        done
);

  localparam int unsigned SEC_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [SEC_W-1:0] ALARM_LAST = SEC_W'(ALARM_SECS - 1);

  nap_state_e state_q, state_d;
  logic [BCD_W-1:0] time_q, time_d;
  logic [BCD_W-1:0] preset_q, preset_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic pend_q, pend_d;
  logic load_err_q, load_err_d;
  logic dec_req_q, dec_req_d;
  logic running_q, running_d;
  logic alarm_q, alarm_d;
  logic done_q, done_d;

  logic pre_en, pre_clr, pre_tick;

  // Prescaler control depends only on state and buttons, never on its own tick.
  assign pre_en = ((state_q == StRun) && !btn_pause) || ((state_q == StAlarm) && !btn_start);

  always_comb begin
    pre_clr = btn_clear || (state_q == StIdle) || ((state_q == StStep) && dec_ack);
`ifdef NAP_TIMER_SNOOZE_EN
    if ((state_q == StAlarm) && btn_snooze && !btn_start) pre_clr = 1'b1;
`endif
  end

  nap_prescaler #(
    .TICKS(TICKS_PER_SEC)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (pre_tick)
  );

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    preset_d   = preset_q;
    secs_d     = secs_q;
    pend_d     = pend_q;
    load_err_d = 1'b0;

    if (btn_clear) begin
      state_d = StIdle;
      time_d  = preset_q;
      secs_d  = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          secs_d = '0;
          if (btn_start) begin
            if (time_q != '0) state_d = StRun;
          end else if (load_en) begin
            if (bcd_valid(load_bcd)) begin
              preset_d = load_bcd;
              time_d   = load_bcd;
            end else begin
              load_err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (btn_pause) begin
            state_d = StPause;
          end else if (pre_tick) begin
            state_d = StStep;
          end
        end
        StStep: begin
          // The handshake always completes; a pause here only takes effect afterwards.
          if (btn_pause) pend_d = 1'b1;
          if (dec_ack) begin
            time_d = dec_next;
            pend_d = 1'b0;
            secs_d = '0;
            if ((dec_next == '0) || dec_zero) begin
              state_d = StAlarm;
            end else if (pend_q || btn_pause) begin
              state_d = StPause;
            end else begin
              state_d = StRun;
            end
          end
        end
        StPause: begin
          if (btn_start) state_d = StRun;
        end
        StAlarm: begin
          if (btn_start) begin
            state_d = StIdle;
`ifdef NAP_TIMER_SNOOZE_EN
          end else if (btn_snooze) begin
            time_d  = SNOOZE_BCD;
            state_d = StRun;
`endif
          end else if (pre_tick) begin
            if (secs_q == ALARM_LAST) begin
              state_d = StIdle;
            end else begin
              secs_d = secs_q + SEC_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    dec_req_d = (state_d == StStep);
    running_d = (state_d == StRun) || (state_d == StStep);
    alarm_d   = (state_d == StAlarm);
    done_d    = (state_d == StAlarm) && (state_q != StAlarm);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      time_q     <= '0;
      preset_q   <= '0;
      secs_q     <= '0;
      pend_q     <= 1'b0;
      load_err_q <= 1'b0;
      dec_req_q  <= 1'b0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      preset_q   <= preset_d;
      secs_q     <= secs_d;
      pend_q     <= pend_d;
      load_err_q <= load_err_d;
      dec_req_q  <= dec_req_d;
      running_q  <= running_d;
      alarm_q    <= alarm_d;
      done_q     <= done_d;
    end
  end

  assign load_err = load_err_q;
  assign dec_req  = dec_req_q;
  assign dec_cur  = time_q;
  assign time_bcd = time_q;
  assign running  = running_q;
  assign alarm    = alarm_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Directed bench for nap_timer_ctrl with a small decrementer model that acks two cycles
// after dec_req rises. Snooze steps compile in only with NAP_TIMER_SNOOZE_EN.
module tb_nap_timer_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_start, btn_pause, btn_clear, btn_snooze;
  logic        load_en;
  logic [23:0] load_bcd;
  logic        load_err, dec_req, dec_ack, dec_zero;
  logic [23:0] dec_cur, dec_next, time_bcd;
  logic        running, alarm, done;

  logic        auto_ack, man_ack, mdl_ack, mdl_zero;
  logic [23:0] man_next, mdl_next;
  logic [1:0]  age;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign dec_ack  = auto_ack ? mdl_ack : man_ack;
  assign dec_next = auto_ack ? mdl_next : man_next;
  assign dec_zero = auto_ack ? mdl_zero : 1'b0;

  nap_timer_ctrl #(
    .TICKS_PER_SEC(4),
    .ALARM_SECS   (2)
  ) dut (
`ifdef NAP_TIMER_SNOOZE_EN
    .btn_snooze(btn_snooze),
`endif
    .clock    (clock),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_clear(btn_clear),
    .load_en  (load_en),
    .load_bcd (load_bcd),
    .load_err (load_err),
    .dec_req  (dec_req),
    .dec_cur  (dec_cur),
    .dec_ack  (dec_ack),
    .dec_next (dec_next),
    .dec_zero (dec_zero),
    .time_bcd (time_bcd),
    .running  (running),
    .alarm    (alarm),
    .done     (done)
  );

  function automatic int bcd2sec(input logic [23:0] v);
    int h, m, s;
    h = 10 * int'(v[23:20]) + int'(v[19:16]);
    m = 10 * int'(v[15:12]) + int'(v[11:8]);
    s = 10 * int'(v[7:4]) + int'(v[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] sec2bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Decrementer model: ack one cycle wide, two cycles after dec_req is first seen.
  always @(posedge clock) begin
    if (reset) begin
      mdl_ack  <= 1'b0;
      mdl_next <= '0;
      mdl_zero <= 1'b0;
      age      <= '0;
    end else if (mdl_ack) begin
      mdl_ack <= 1'b0;
      age     <= '0;
    end else if (dec_req) begin
      if (age == 2'd1) begin
        mdl_ack  <= 1'b1;
        mdl_zero <= (dec_cur == '0);
        mdl_next <= (bcd2sec(dec_cur) > 0) ? sec2bcd(bcd2sec(dec_cur) - 1) : '0;
      end else begin
        age <= age + 2'd1;
      end
    end else begin
      age <= '0;
    end
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_load(input logic [23:0] v);
    load_bcd = v;
    load_en  = 1'b1;
    cyc();
    load_en  = 1'b0;
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    cyc();
    btn_clear = 1'b0;
  endtask

  task automatic wait_rise(input string tag);
    for (int i = 0; i < 30 && dec_req !== 1'b1; i++) cyc();
    chk1({tag, "_req_rise"}, dec_req, 1'b1);
  endtask

  task automatic wait_fall(input string tag);
    for (int i = 0; i < 30 && dec_req !== 1'b0; i++) cyc();
    chk1({tag, "_req_fall"}, dec_req, 1'b0);
  endtask

  task automatic hold_no_req(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      seen = seen | dec_req;
    end
    chk1({tag, "_no_req"}, seen, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0; btn_snooze = 1'b0;
    load_en = 1'b0; load_bcd = '0;
    auto_ack = 1'b1; man_ack = 1'b0; man_next = '0;
    repeat (3) cyc();
    chk("rst_time", time_bcd, 24'h000000);
    chk1("rst_running", running, 1'b0);
    chk1("rst_alarm", alarm, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_dec_req", dec_req, 1'b0);
    chk1("rst_load_err", load_err, 1'b0);
    reset = 1'b0;
    cyc();

    // 1: three-second countdown to alarm and auto-return
    do_load(24'h000003);
    chk("t1_load", time_bcd, 24'h000003);
    chk1("t1_load_err", load_err, 1'b0);
    press_start();
    chk1("t1_running", running, 1'b1);
    repeat (3) cyc();
    chk1("t1_req_early", dec_req, 1'b0);
    cyc();
    chk1("t1_req_on", dec_req, 1'b1);
    chk("t1_dec_cur", dec_cur, 24'h000003);
    wait_fall("t1a");
    chk("t1_time2", time_bcd, 24'h000002);
    wait_rise("t1b");
    wait_fall("t1b");
    chk("t1_time1", time_bcd, 24'h000001);
    wait_rise("t1c");
    wait_fall("t1c");
    chk("t1_time0", time_bcd, 24'h000000);
    chk1("t1_done", done, 1'b1);
    chk1("t1_alarm", alarm, 1'b1);
    chk1("t1_run_off", running, 1'b0);
    cyc();
    chk1("t1_done_pulse", done, 1'b0);
    repeat (6) cyc();
    chk1("t1_alarm_hold", alarm, 1'b1);
    cyc();
    chk1("t1_alarm_exp", alarm, 1'b0);
    chk("t1_time_idle", time_bcd, 24'h000000);

    // 2: minute borrow
    do_load(24'h000100);
    press_start();
    wait_rise("t2");
    wait_fall("t2");
    chk("t2_time", time_bcd, 24'h000059);
    chk1("t2_running", running, 1'b1);
    press_clear();
    chk("t2_clear_time", time_bcd, 24'h000100);
    chk1("t2_clear_run", running, 1'b0);

    // 3: pause with a partial second, resume keeps the count
    press_start();
    wait_rise("t3");
    wait_fall("t3");
    chk("t3_time", time_bcd, 24'h000059);
    repeat (2) cyc();
    press_pause();
    chk1("t3_paused", running, 1'b0);
    hold_no_req("t3", 10);
    press_start();
    chk1("t3_resumed", running, 1'b1);
    cyc();
    chk1("t3_req_early", dec_req, 1'b0);
    cyc();
    chk1("t3_req_on", dec_req, 1'b1);

    // 4: pause during the handshake is deferred until the ack
    press_pause();
    chk1("t4_req_held", dec_req, 1'b1);
    wait_fall("t4");
    chk("t4_time", time_bcd, 24'h000058);
    chk1("t4_paused", running, 1'b0);
    hold_no_req("t4", 8);
    press_start();
    chk1("t4_resumed", running, 1'b1);

    // 5: clear mid-handshake, late ack ignored
    auto_ack = 1'b0;
    wait_rise("t5");
    chk("t5_dec_cur", dec_cur, 24'h000058);
    press_clear();
    chk1("t5_req_drop", dec_req, 1'b0);
    chk("t5_time", time_bcd, 24'h000100);
    man_next = 24'h000057;
    man_ack  = 1'b1;
    cyc();
    man_ack  = 1'b0;
    cyc();
    chk("t5_ack_ignored", time_bcd, 24'h000100);
    chk1("t5_idle", running, 1'b0);
    auto_ack = 1'b1;

    // 6: invalid loads rejected, zero start ignored
    do_load(24'h006000);
    chk1("t6_err_m10", load_err, 1'b1);
    chk("t6_time_kept", time_bcd, 24'h000100);
    cyc();
    chk1("t6_err_pulse", load_err, 1'b0);
    do_load(24'h000060);
    chk1("t6_err_s10", load_err, 1'b1);
    press_clear();
    chk("t6_preset_kept", time_bcd, 24'h000100);
    do_load(24'h000000);
    chk("t6_zero_load", time_bcd, 24'h000000);
    chk1("t6_zero_err", load_err, 1'b0);
    press_start();
    chk1("t6_zero_start", running, 1'b0);
    hold_no_req("t6", 6);

`ifdef NAP_TIMER_SNOOZE_EN
    do_load(24'h000001);
    press_start();
    wait_rise("sn");
    wait_fall("sn");
    chk1("sn_alarm", alarm, 1'b1);
    btn_snooze = 1'b1;
    cyc();
    btn_snooze = 1'b0;
    chk("sn_time", time_bcd, 24'h000500);
    chk1("sn_running", running, 1'b1);
    chk1("sn_alarm_off", alarm, 1'b0);
    press_clear();
    chk("sn_preset", time_bcd, 24'h000001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
